// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C command arbiter: FSM encodings and
// bit positions inside the 5-bit i2c_master command flag word.
package i2c_arb_pkg;

    // Command flag word is {start, read, write, write_multiple, stop}
    localparam int CMD_FLAG_W         = 5;
    localparam int CMD_STOP           = 0;
    localparam int CMD_WRITE_MULTIPLE = 1;
    localparam int CMD_WRITE          = 2;
    localparam int CMD_READ           = 3;
    localparam int CMD_START          = 4;

    // Flag word issued when the arbiter has to close an abandoned transaction
    localparam logic [CMD_FLAG_W-1:0] FLAGS_STOP_ONLY = CMD_FLAG_W'(1 << CMD_STOP);

    // Arbiter FSM encoding
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE       = 2'd0;
    localparam arb_state_t ST_GRANT      = 2'd1;
    localparam arb_state_t ST_DRAIN      = 2'd2;
    localparam arb_state_t ST_FORCE_STOP = 2'd3;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin finder: returns the first set request at or
// after ptr, wrapping around the top of the vector.
module i2c_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N < 2) ? 1 : $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    // Scan N positions starting from ptr; the first hit wins
    always_comb begin
        int j;
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = IW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one i2c_master command/data interface between NUM_REQ requesters.
// Ownership is granted per transaction (round-robin) and held until the
// stop has finished on the wire; an owner that goes quiet gets a forced stop.
module i2c_cmd_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ*7-1:0]          r_cmd_addr,
    input  logic [NUM_REQ*CMD_FLAG_W-1:0] r_cmd_flags,
    input  logic [NUM_REQ-1:0]            r_cmd_valid,
    output logic [NUM_REQ-1:0]            r_cmd_ready,
    input  logic [NUM_REQ*8-1:0]          r_wr_tdata,
    input  logic [NUM_REQ-1:0]            r_wr_tvalid,
    input  logic [NUM_REQ-1:0]            r_wr_tlast,
    output logic [NUM_REQ-1:0]            r_wr_tready,
    output logic [NUM_REQ*8-1:0]          r_rd_tdata,
    output logic [NUM_REQ-1:0]            r_rd_tvalid,
    output logic [NUM_REQ-1:0]            r_rd_tlast,
    input  logic [NUM_REQ-1:0]            r_rd_tready,
    output logic [6:0]                    m_cmd_addr,
    output logic [CMD_FLAG_W-1:0]         m_cmd_flags,
    output logic                          m_cmd_valid,
    input  logic                          m_cmd_ready,
    output logic [7:0]                    m_wr_tdata,
    output logic                          m_wr_tvalid,
    output logic                          m_wr_tlast,
    input  logic                          m_wr_tready,
    input  logic [7:0]                    m_rd_tdata,
    input  logic                          m_rd_tvalid,
    input  logic                          m_rd_tlast,
    output logic                          m_rd_tready,
    input  logic                          i2c_busy,
    input  logic                          i2c_missed_ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            req_missed_ack,
    output logic                          timeout_pulse
);

    localparam int IW = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 pulse_q, pulse_d;
    logic [NUM_REQ-1:0]   nack_q, nack_d;

    logic                 pick_any;
    logic [IW-1:0]        pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;

    int                   own_i;
    logic                 cmd_route, data_route;
    logic                 cmd_hs, wr_hs, rd_hs;

    assign own_i = int'(owner_q);

    // The command path is only open while granted; data keeps flowing until
    // the lock drops so bytes behind an accepted stop still reach the owner.
    assign cmd_route  = (state_q == ST_GRANT);
    assign data_route = (state_q != ST_IDLE);

    assign cmd_hs = cmd_route  && r_cmd_valid[own_i] && m_cmd_ready;
    assign wr_hs  = data_route && r_wr_tvalid[own_i] && m_wr_tready;
    assign rd_hs  = data_route && m_rd_tvalid && r_rd_tready[own_i];

    i2c_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req    (r_cmd_valid),
        .ptr    (ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Owner-to-master mux; FORCE_STOP substitutes a bare stop command
    always_comb begin
        m_cmd_valid = 1'b0;
        m_cmd_addr  = '0;
        m_cmd_flags = '0;
        if (state_q == ST_GRANT) begin
            m_cmd_valid = r_cmd_valid[own_i];
            m_cmd_addr  = r_cmd_addr[own_i*7 +: 7];
            m_cmd_flags = r_cmd_flags[own_i*CMD_FLAG_W +: CMD_FLAG_W];
        end else if (state_q == ST_FORCE_STOP) begin
            m_cmd_valid = 1'b1;
            m_cmd_flags = FLAGS_STOP_ONLY;
        end
        m_wr_tdata  = data_route ? r_wr_tdata[own_i*8 +: 8] : 8'h00;
        m_wr_tvalid = data_route && r_wr_tvalid[own_i];
        m_wr_tlast  = data_route && r_wr_tlast[own_i];
        m_rd_tready = data_route && r_rd_tready[own_i];
    end

    // Per-requester return paths: only the owner ever sees readies or read beats.
    // The sticky NACK flag is set by a missed ack while owned and cleared by the
    // owner's next accepted command; a simultaneous set takes priority.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign r_cmd_ready[gi]          = cmd_route  && grant_q[gi] && m_cmd_ready;
            assign r_wr_tready[gi]          = data_route && grant_q[gi] && m_wr_tready;
            assign r_rd_tvalid[gi]          = data_route && grant_q[gi] && m_rd_tvalid;
            assign r_rd_tlast[gi]           = data_route && grant_q[gi] && m_rd_tlast;
            assign r_rd_tdata[gi*8 +: 8]    = (data_route && grant_q[gi]) ? m_rd_tdata : 8'h00;
            assign nack_d[gi] = (i2c_missed_ack && grant_q[gi]) ||
                                (nack_q[gi] && !(cmd_hs && grant_q[gi]));
        end
    endgenerate

    // Arbitration FSM, owner idle timeout and release pointer update
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (cmd_hs && r_cmd_flags[own_i*CMD_FLAG_W + CMD_STOP]) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else if (cmd_hs || wr_hs || rd_hs) begin
                    cnt_d = '0;
                end else if (TIMEOUT_CYC != 0) begin
                    if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                        state_d = ST_FORCE_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FORCE_STOP: begin
                if (m_cmd_ready) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!i2c_busy) begin
                    grant_d = '0;
                    ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset drops ownership at once without touching the bus
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            nack_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            nack_q  <= nack_d;
        end
    end

    assign grant          = grant_q;
    assign req_missed_ack = nack_q;
    assign timeout_pulse  = pulse_q;

endmodule
